div_req_frontend: RTL and testbench
===================================

// Module: div_req_frontend
// PURPOSE
//  Request front-end sitting directly upstream of the 8-bit iterative divider.
//  Buffers divide requests in a FIFO and issues them one at a time via a single-cycle
//  div_i_valid pulse. Captures the divider's one-cycle result pulse into a held,
//  backpressured output.
//  Traps divide-by-zero locally, because the divider never terminates on divisor 0.
// PARAMETERS
//  DEPTH  4  request FIFO entries; power of 2, >=2
//  TAG_W  4  width of the opaque request tag returned with each result
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      request offered
//  in_ready     out  1      FIFO can accept (= !full)
//  in_dividend  in   8      request dividend
//  in_divisor   in   8      request divisor
//  in_tag       in   TAG_W  request tag
//  div_i_valid  out  1      issue pulse to divider (one cycle)
//  div_dividend out  8      dividend to divider, valid with div_i_valid
//  div_divisor  out  8      divisor to divider, valid with div_i_valid
//  div_busy     in   1      divider busy flag
//  div_o_valid  in   1      divider result pulse
//  div_q        in   8      divider quotient, valid with div_o_valid
//  div_rem      in   8      divider remainder, valid with div_o_valid
//  out_valid    out  1      result held
//  out_ready    in   1      consumer accepts result
//  out_q        out  8      quotient
//  out_rem      out  8      remainder
//  out_tag      out  TAG_W  tag of the originating request
//  out_dbz      out  1      1 = divide-by-zero result
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FIFO empty, FSM=IDLE; div_i_valid, out_valid, out_q, out_rem, out_tag, out_dbz all 0.
//   - div_dividend/div_divisor = 0; in_ready=1 once rst_n is released.
//  FIFO:
//   - Push on in_valid&&in_ready; pop only on issue or DBZ trap.
//   - in_ready depends on occupancy only; no pass-through when full.
//   - Simultaneous push+pop when not full keeps the count unchanged; pointers wrap modulo DEPTH.
//  FSM IDLE: acts only when FIFO is non-empty and out_valid==0.
//   - Head divisor==0: pop; next cycle out_valid=1, out_q=8'hFF, out_rem=head dividend,
//     out_dbz=1, out_tag=head tag. No div_i_valid; stay IDLE.
//   - Head divisor!=0 and div_busy==0: pop; registered div_i_valid=1 for exactly one cycle,
//     with div_dividend/div_divisor/tag latched from head; go WAIT.
//   - Any div_o_valid seen in IDLE (stale, e.g. after front-end reset) is dropped.
//  FSM WAIT:
//   - Ignore div_busy; div_i_valid held 0.
//   - On div_o_valid: out_q=div_q, out_rem=div_rem, out_tag=latched tag, out_dbz=0,
//     out_valid=1 next cycle; go IDLE.
//   - Latency from div_i_valid to out_valid is quotient+3 cycles.
//  Output:
//   - out_* stable while out_valid && !out_ready; cleared to out_valid=0 on handshake.
//   - New issue/trap is not started in the handshake cycle; earliest is the following cycle.
//  Ordering: results are strictly in request order; at most one request is in flight.
//  Reset mid-operation: everything clears immediately. The divider may still finish;
//   div_busy blocks the next issue and its late div_o_valid is dropped in IDLE.
// TESTING
//  1. 100/7 tag 3, out_ready=1 -> one div_i_valid pulse; out_q=14, out_rem=2, out_tag=3, out_dbz=0.
//  2. 5/0 tag 1 -> no div_i_valid; out_valid next cycle, out_q=8'hFF, out_rem=5, out_dbz=1.
//  3. Divider model holds div_busy=1, push 4 requests -> in_ready=0 after 4th, 5th not accepted;
//     all 4 results later returned in order.
//  4. 20/4, 9/0, 3/5 back-to-back -> results (5,0,dbz0), (FF,9,dbz1), (0,3,dbz0) in order.
//  5. out_ready=0 for 10 cycles with result held -> out_* stable, no div_i_valid;
//     after handshake the next issue occurs in the following cycle.
//  6. rst_n low while WAIT -> outputs 0 asynchronously; later div_o_valid ignored;
//     next request issues only once div_busy=0.

Source files
------------

// File: rtl/div_req_frontend.sv
// div_req_frontend: request front-end for the 8-bit iterative divider.
// Buffers divide requests in a FIFO and issues them one at a time to the divider.
// The divider's one-cycle result pulse is captured into a held, backpressured
// output. Divide-by-zero is trapped locally because the divider never finishes
// on a zero divisor.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            request handshake (in_ready = FIFO not full)
//   in_dividend/in_divisor/in_tag  request payload
//   div_i_valid                  one-cycle issue pulse to the divider
//   div_dividend/div_divisor     operands, valid with div_i_valid
//   div_busy                     divider busy flag
//   div_o_valid/div_q/div_rem    divider result pulse and payload
//   out_valid/out_ready          result handshake
//   out_q/out_rem/out_tag/out_dbz  held result payload (out_dbz = divide-by-zero)
module div_req_frontend #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_dividend,
    input  logic [7:0]       in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_i_valid,
    output logic [7:0]       div_dividend,
    output logic [7:0]       div_divisor,
    input  logic             div_busy,
    input  logic             div_o_valid,
    input  logic [7:0]       div_q,
    input  logic [7:0]       div_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_q,
    output logic [7:0]       out_rem,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] dividend;
        logic [DATA_W-1:0] divisor;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    req_t               mem [DEPTH];
    req_t               head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               push, pop;
    logic [TAG_W-1:0]   tag_lat, tag_lat_nxt;

    logic               div_i_valid_nxt;
    logic [DATA_W-1:0]  div_dividend_nxt, div_divisor_nxt;
    logic               out_valid_nxt, out_dbz_nxt;
    logic [DATA_W-1:0]  out_q_nxt, out_rem_nxt;
    logic [TAG_W-1:0]   out_tag_nxt;

    assign push      = in_valid && in_ready;
    assign head      = mem[rd_ptr];
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    // FIFO storage; no reset needed, occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dividend: in_dividend, divisor: in_divisor, tag: in_tag};
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_nxt        = state;
        pop              = 1'b0;
        tag_lat_nxt      = tag_lat;
        div_i_valid_nxt  = 1'b0;
        div_dividend_nxt = div_dividend;
        div_divisor_nxt  = div_divisor;
        out_valid_nxt    = out_valid;
        out_q_nxt        = out_q;
        out_rem_nxt      = out_rem;
        out_tag_nxt      = out_tag;
        out_dbz_nxt      = out_dbz;

        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                // out_valid gating also blocks a new start in the handshake cycle
                if ((count != CNT_W'(0)) && !out_valid) begin
                    if (head.divisor == DATA_W'(0)) begin
                        pop           = 1'b1;
                        out_valid_nxt = 1'b1;
                        out_q_nxt     = 8'hFF;
                        out_rem_nxt   = head.dividend;
                        out_tag_nxt   = head.tag;
                        out_dbz_nxt   = 1'b1;
                    end else if (!div_busy) begin
                        pop              = 1'b1;
                        div_i_valid_nxt  = 1'b1;
                        div_dividend_nxt = head.dividend;
                        div_divisor_nxt  = head.divisor;
                        tag_lat_nxt      = head.tag;
                        state_nxt        = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (div_o_valid) begin
                    out_valid_nxt = 1'b1;
                    out_q_nxt     = div_q;
                    out_rem_nxt   = div_rem;
                    out_tag_nxt   = tag_lat;
                    out_dbz_nxt   = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, pointers and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            in_ready     <= 1'b1;
            tag_lat      <= '0;
            div_i_valid  <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            out_valid    <= 1'b0;
            out_q        <= '0;
            out_rem      <= '0;
            out_tag      <= '0;
            out_dbz      <= 1'b0;
        end else begin
            state        <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count        <= count_nxt;
            in_ready     <= (count_nxt != CNT_W'(DEPTH));
            tag_lat      <= tag_lat_nxt;
            div_i_valid  <= div_i_valid_nxt;
            div_dividend <= div_dividend_nxt;
            div_divisor  <= div_divisor_nxt;
            out_valid    <= out_valid_nxt;
            out_q        <= out_q_nxt;
            out_rem      <= out_rem_nxt;
            out_tag      <= out_tag_nxt;
            out_dbz      <= out_dbz_nxt;
        end
    end

endmodule

// File: tb/tb_div_req_frontend.sv
// Testbench for div_req_frontend with a behavioural divider model and a
// queue-based reference of expected results.
module tb_div_req_frontend;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] rem;
        logic [3:0] tag;
        logic       dbz;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_dividend = '0;
    logic [7:0] in_divisor = '0;
    logic [3:0] in_tag = '0;
    logic       div_i_valid;
    logic [7:0] div_dividend;
    logic [7:0] div_divisor;
    logic       div_busy;
    logic       div_o_valid = 1'b0;
    logic [7:0] div_q = '0;
    logic [7:0] div_rem = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_q;
    logic [7:0] out_rem;
    logic [3:0] out_tag;
    logic       out_dbz;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    div_req_frontend #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
        .div_i_valid(div_i_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_o_valid(div_o_valid), .div_q(div_q), .div_rem(div_rem),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_rem(out_rem), .out_tag(out_tag), .out_dbz(out_dbz)
    );

    // Divider model: busy for quotient+1 cycles after the issue, then one result pulse.
    // It is never reset by rst_n, like the real divider.
    logic       mdl_busy = 1'b0;
    logic       mdl_run  = 1'b0;
    logic       hold_busy = 1'b0;
    int         mdl_cnt = 0;
    int         mdl_done_cnt = 0;
    logic [7:0] mdl_q = '0;
    logic [7:0] mdl_r = '0;

    assign div_busy = mdl_busy | hold_busy;

    always @(posedge clk) begin
        div_o_valid <= 1'b0;
        if (mdl_run) begin
            if (mdl_cnt == 0) begin
                div_o_valid  <= 1'b1;
                div_q        <= mdl_q;
                div_rem      <= mdl_r;
                mdl_run      <= 1'b0;
                mdl_busy     <= 1'b0;
                mdl_done_cnt <= mdl_done_cnt + 1;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end else if (div_i_valid) begin
            mdl_run  <= 1'b1;
            mdl_busy <= 1'b1;
            if (div_divisor == 8'd0) begin
                mdl_q   <= 8'hFF;
                mdl_r   <= div_dividend;
                mdl_cnt <= 1;
            end else begin
                mdl_q   <= div_dividend / div_divisor;
                mdl_r   <= div_dividend % div_divisor;
                mdl_cnt <= int'(div_dividend / div_divisor);
            end
        end
    end

    // Observation: collect completed handshakes and issue pulses away from the active edge
    res_t got_q[$];
    res_t exp_q[$];
    int   issue_cnt = 0;
    int   run_len = 0;
    int   max_run = 0;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            got_q.push_back(res_t'({out_q, out_rem, out_tag, out_dbz}));
        if (rst_n && div_i_valid) begin
            issue_cnt = issue_cnt + 1;
            run_len   = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    // Reference: what the consumer must see for a request, from plain arithmetic
    function automatic res_t ref_result(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] t);
        res_t r;
        if (b == 8'd0) begin
            r.q = 8'hFF; r.rem = a; r.dbz = 1'b1;
        end else begin
            r.q = a / b; r.rem = a % b; r.dbz = 1'b0;
        end
        r.tag = t;
        return r;
    endfunction

    // One push attempt; entered and left at posedge+1
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                        output bit ok);
        in_valid = 1'b1; in_dividend = a; in_divisor = b; in_tag = t;
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (ok) exp_q.push_back(ref_result(a, b, t));
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (got_q.size() < n) begin
            $display("FAIL wait_got: got %0d results, need %0d within %0d cycles",
                     got_q.size(), n, budget);
            fails++; checks++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if ({out_valid, div_i_valid, out_q, out_rem, out_tag, out_dbz, div_dividend, div_divisor} !== '0) begin
            $display("FAIL reset_outputs: out_valid=%b div_i_valid=%b out_q=%h out_rem=%h out_tag=%h out_dbz=%b div_dividend=%h div_divisor=%h, want all 0",
                     out_valid, div_i_valid, out_q, out_rem, out_tag, out_dbz, div_dividend, div_divisor);
            fails++;
        end
        checks++;
        rst_n = 1'b1;
        @(negedge clk);
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b want 1", in_ready); fails++;
        end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bit   ok;
        int   i0 = issue_cnt;
        res_t g, e;
        res_t c = {8'd14, 8'd2, 4'd3, 1'b0};
        out_ready = 1'b1;
        push(8'd100, 8'd7, 4'd3, ok);
        wait_got(1, 200);
        g = (got_q.size() > 0) ? got_q.pop_front() : '1;
        e = exp_q.pop_front();
        if (g !== c) begin
            $display("FAIL single_const: got %h want %h", g, c); fails++;
        end
        checks++;
        if (g !== e) begin
            $display("FAIL single_model: got %h want %h", g, e); fails++;
        end
        checks++;
        if (issue_cnt - i0 != 1) begin
            $display("FAIL single_issue_count: got %0d want 1", issue_cnt - i0); fails++;
        end
        checks++;
    endtask

    task automatic test_dbz();
        bit   ok;
        int   i0 = issue_cnt;
        res_t g, e;
        out_ready = 1'b1;
        push(8'd5, 8'd0, 4'd1, ok);
        @(negedge clk);
        if (out_valid !== 1'b0) begin
            $display("FAIL dbz_early: out_valid got %b want 0", out_valid); fails++;
        end
        checks++;
        @(negedge clk);
        if ({out_valid, out_q, out_rem, out_tag, out_dbz} !== {1'b1, 8'hFF, 8'd5, 4'd1, 1'b1}) begin
            $display("FAIL dbz_next_cycle: got v=%b q=%h rem=%h tag=%h dbz=%b want v=1 q=ff rem=05 tag=1 dbz=1",
                     out_valid, out_q, out_rem, out_tag, out_dbz); fails++;
        end
        checks++;
        @(posedge clk); #1;
        wait_got(1, 20);
        g = (got_q.size() > 0) ? got_q.pop_front() : '1;
        e = exp_q.pop_front();
        if (g !== e) begin
            $display("FAIL dbz_model: got %h want %h", g, e); fails++;
        end
        checks++;
        if (issue_cnt != i0) begin
            $display("FAIL dbz_no_issue: issues got %0d want 0", issue_cnt - i0); fails++;
        end
        checks++;
    endtask

    task automatic test_full();
        bit   ok;
        int   acc = 0;
        res_t g, e;
        out_ready = 1'b1;
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(8'($urandom), 8'($urandom_range(1, 255)), 4'(i + 8), ok);
            if (ok) acc++;
        end
        if (acc != 4) begin
            $display("FAIL full_accept: accepted %0d want 4", acc); fails++;
        end
        checks++;
        @(negedge clk);
        if (in_ready !== 1'b0) begin
            $display("FAIL full_in_ready: got %b want 0", in_ready); fails++;
        end
        checks++;
        @(posedge clk); #1;
        push(8'd77, 8'd7, 4'd15, ok);
        if (ok) begin
            $display("FAIL full_fifth: accepted got 1 want 0"); fails++;
        end
        checks++;
        hold_busy = 1'b0;
        wait_got(4, 2000);
        for (int i = 0; i < 4; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (g !== e) begin
                $display("FAIL full_order[%0d]: got %h want %h", i, g, e); fails++;
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        res_t g, e;
        res_t c[3];
        c[0] = {8'd5,  8'd0, 4'd2, 1'b0};
        c[1] = {8'hFF, 8'd9, 4'd6, 1'b1};
        c[2] = {8'd0,  8'd3, 4'd7, 1'b0};
        out_ready = 1'b1;
        push(8'd20, 8'd4, 4'd2, ok);
        push(8'd9,  8'd0, 4'd6, ok);
        push(8'd3,  8'd5, 4'd7, ok);
        wait_got(3, 300);
        for (int i = 0; i < 3; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (g !== e || g !== c[i]) begin
                $display("FAIL b2b[%0d]: got %h want %h", i, g, c[i]); fails++;
            end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   k = 0;
        int   i0;
        logic [20:0] snap;
        res_t g, e;
        out_ready = 1'b0;
        push(8'd50, 8'd5, 4'd4, ok);
        push(8'd60, 8'd6, 4'd5, ok);
        while (!out_valid && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (!out_valid) begin
            $display("FAIL bp_wait_valid: out_valid got 0 want 1"); fails++;
        end
        checks++;
        snap = {out_q, out_rem, out_tag, out_dbz};
        i0 = issue_cnt;
        repeat (10) begin
            @(negedge clk);
            if ({out_valid, out_q, out_rem, out_tag, out_dbz} !== {1'b1, snap}) begin
                $display("FAIL bp_stable: got %h want %h", {out_valid, out_q, out_rem, out_tag, out_dbz}, {1'b1, snap});
                fails++;
            end
            checks++;
        end
        if (issue_cnt != i0) begin
            $display("FAIL bp_no_issue: issues got %0d want 0", issue_cnt - i0); fails++;
        end
        checks++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if ({out_valid, div_i_valid} !== 2'b00) begin
            $display("FAIL bp_handshake_cycle: out_valid=%b div_i_valid=%b want 0 0", out_valid, div_i_valid);
            fails++;
        end
        checks++;
        @(negedge clk);
        if (div_i_valid !== 1'b1) begin
            $display("FAIL bp_next_issue: div_i_valid got %b want 1", div_i_valid); fails++;
        end
        checks++;
        @(posedge clk); #1;
        wait_got(2, 300);
        for (int i = 0; i < 2; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (g !== e) begin
                $display("FAIL bp_result[%0d]: got %h want %h", i, g, e); fails++;
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   k = 0;
        int   i0, d0;
        res_t g, e;
        out_ready = 1'b1;
        i0 = issue_cnt;
        push(8'd200, 8'd3, 4'd9, ok);
        while (issue_cnt == i0 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        if ({out_valid, div_i_valid, out_q, out_rem, out_tag, out_dbz, div_dividend, div_divisor} !== '0) begin
            $display("FAIL midreset_async: out_valid=%b div_i_valid=%b div_dividend=%h div_divisor=%h out_q=%h want all 0",
                     out_valid, div_i_valid, div_dividend, div_divisor, out_q);
            fails++;
        end
        checks++;
        exp_q.delete();
        got_q.delete();
        d0 = mdl_done_cnt;
        i0 = issue_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(8'd10, 8'd2, 4'd11, ok);
        k = 0;
        while (issue_cnt == i0 && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (!(issue_cnt > i0 && mdl_done_cnt > d0)) begin
            $display("FAIL midreset_issue_after_idle: issued=%0d stale_done=%0d want 1 1",
                     issue_cnt - i0, mdl_done_cnt - d0);
            fails++;
        end
        checks++;
        wait_got(1, 100);
        repeat (5) @(posedge clk);
        #1;
        g = (got_q.size() > 0) ? got_q.pop_front() : '1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (g !== e) begin
            $display("FAIL midreset_result: got %h want %h", g, e); fails++;
        end
        checks++;
        if (got_q.size() != 0) begin
            $display("FAIL midreset_stale_dropped: extra results got %0d want 0", got_q.size()); fails++;
            got_q.delete();
        end
        checks++;
    endtask

    task automatic test_random();
        bit   ok;
        int   n = 0;
        res_t g, e;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            ok = 1'b0;
            for (int t = 0; t < 400 && !ok; t++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                push(a, b, 4'($urandom), ok);
            end
            if (ok) n++;
        end
        if (n != 24) begin
            $display("FAIL rand_accept: accepted %0d want 24", n); fails++;
        end
        checks++;
        out_ready = 1'b1;
        wait_got(exp_q.size(), 8000);
        while (exp_q.size() > 0) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            e = exp_q.pop_front();
            if (g !== e) begin
                $display("FAIL rand_result: got %h want %h", g, e); fails++;
            end
            checks++;
        end
        if (max_run != 1) begin
            $display("FAIL issue_pulse_width: got %0d cycles want 1", max_run); fails++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dbz();
        test_full();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
